gray_seq_ctrl: RTL and testbench
================================

Name: gray_seq_ctrl

Overview:
Programmable Gray-code sequence generator and controller. It steps a binary index between configurable lower and upper limits, and presents each index with its Gray equivalent over a valid/ready stream. Three modes are supported: one-shot, continuous wrap and ping-pong. It sits ahead of encoder-driven loads such as LED/stepper phase drivers and Gray-pointer test stimulus, and is the sequencing layer around the binary-to-Gray conversion.

Parameters:
DATA_SIZE, 4, width of the binary index and the Gray output (legal 2..16)
CNT_W, 16, width of the transferred-beat counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  start request; sampled only in IDLE
stop  input  1  abort request; sampled only in RUN
mode  input  2  0 = one-shot up, 1 = wrap up, 2 = ping-pong, 3 = reserved (treated as error)
lo_lim  input  DATA_SIZE  lower index limit, latched at start
hi_lim  input  DATA_SIZE  upper index limit, latched at start
out_ready  input  1  sink ready
out_valid  output  1  bin_out/gray_out valid
bin_out  output  DATA_SIZE  current binary index
gray_out  output  DATA_SIZE  Gray code of bin_out, computed as bin ^ (bin >> 1)
dir_out  output  1  1 = counting up, 0 = counting down
busy  output  1  high in RUN
done  output  1  one-cycle pulse on one-shot completion
cfg_err  output  1  one-cycle pulse on rejected start
beat_cnt  output  CNT_W  beats transferred since the last accepted start; saturates at all-ones

Behaviour:
- Reset (async assert, sync release): state IDLE; out_valid=0, bin_out=0, gray_out=0, dir_out=1, busy=0, done=0, cfg_err=0, beat_cnt=0; latched limits and mode = 0.
- All outputs are registered. gray_out is always the Gray code of the same-cycle bin_out; both are updated in the same edge from the next-index value.
- Beat = rising edge with out_valid && out_ready.
- FSM states: IDLE, RUN.
- IDLE behaviour:
  - start=1 with lo_lim<=hi_lim and mode!=3: latch lo/hi/mode; bin_out=lo; dir_out=1; beat_cnt=0; out_valid=1; busy=1; go RUN. Latency: start at edge N gives first valid at edge N+1.
  - start=1 with lo_lim>hi_lim or mode=3: cfg_err=1 for one cycle; stay IDLE; nothing latched.
- RUN, valid/ready rules:
  - out_valid stays 1 and bin_out/gray_out/dir_out stay stable while out_ready=0; no advance.
  - On each beat, beat_cnt increments (saturating) and the index advances per mode.
- RUN, advance per mode:
  - one-shot: if bin==hi, go IDLE with out_valid=0, busy=0, done=1 (one cycle); bin_out/gray_out hold the last value. Otherwise bin+1.
  - wrap: if bin==hi, next is lo; otherwise bin+1. Runs until stop.
  - ping-pong: if up and bin==hi, set dir=0 and next is hi-1. If down and bin==lo, set dir=1 and next is lo+1. Otherwise bin±1.
  - ping-pong with lo==hi: index holds at lo, dir_out stays 1, beats still counted.
- stop in RUN: next edge goes IDLE with out_valid=0, busy=0, no done. If a beat occurs in the same cycle, it is counted in beat_cnt but the index does not advance.
- start is ignored in RUN; stop is ignored in IDLE.
- Limit and mode inputs may change during RUN without effect; only latched values are used.
- Full index range (lo=0, hi=2^DATA_SIZE-1) must not overflow. Wrap/ping-pong boundary checks use limit compares, never arithmetic overflow.
- rst_n asserted mid-run: immediate return to the reset state, regardless of handshake.

Test Plan:
- Reset/idle: hold rst_n=0 with random inputs, then release -> all outputs at reset values; out_valid stays 0 with no start.
- One-shot, DATA_SIZE=4, lo=3, hi=6, ready=1 -> bin 3,4,5,6 / gray 2,6,7,5 on consecutive cycles; done pulses once; beat_cnt=4; out_valid drops.
- Wrap with backpressure: lo=14, hi=15, mode=1, ready toggling 1,0,1,1,0,1 -> sequence 14,15,14,15 with values held stable on ready=0 cycles; then stop -> out_valid=0, done stays 0, beat_cnt=4.
- Ping-pong: lo=0, hi=3 -> bin 0,1,2,3,2,1,0,1; dir_out falls after the beat at 3 and rises after the beat at 0; gray_out stays the Gray code of bin_out throughout (0,1,3,2,3,1,0,1).
- Config errors: start with lo=9, hi=2, then start with mode=3 -> cfg_err pulses each time, busy=0, out_valid=0; a subsequent legal start works normally.
- Async reset mid-run: assert rst_n=0 between clock edges during a wrap run -> outputs clear immediately, with no done or cfg_err pulse.

Source files
------------

// File: rtl/gray_seq_ctrl.sv
// -----------------------------------------------------------------------------
// gray_seq_ctrl
//   Programmable Gray-code sequence generator. Steps a binary index between
//   latched lower/upper limits and streams each index with its Gray code over
//   a valid/ready interface. Modes: one-shot up, wrap up, ping-pong.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      start request (IDLE only)
//   stop       abort request (RUN only)
//   mode       0 one-shot, 1 wrap, 2 ping-pong, 3 reserved (rejected)
//   lo_lim     lower index limit, latched at start
//   hi_lim     upper index limit, latched at start
//   out_ready  sink ready
//   out_valid  bin_out/gray_out valid
//   bin_out    current binary index
//   gray_out   Gray code of bin_out
//   dir_out    1 = counting up, 0 = counting down
//   busy       high while running
//   done       one-cycle pulse on one-shot completion
//   cfg_err    one-cycle pulse on a rejected start
//   beat_cnt   beats since last accepted start, saturating
// -----------------------------------------------------------------------------
module gray_seq_ctrl #(
    parameter int DATA_SIZE = 4,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic [1:0]           mode,
    input  logic [DATA_SIZE-1:0] lo_lim,
    input  logic [DATA_SIZE-1:0] hi_lim,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [DATA_SIZE-1:0] bin_out,
    output logic [DATA_SIZE-1:0] gray_out,
    output logic                 dir_out,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err,
    output logic [CNT_W-1:0]     beat_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [1:0] MODE_ONESHOT  = 2'd0;
    localparam logic [1:0] MODE_WRAP     = 2'd1;
    localparam logic [1:0] MODE_PINGPONG = 2'd2;
    localparam logic [1:0] MODE_RSVD     = 2'd3;

    state_t               state_q, state_n;
    logic [DATA_SIZE-1:0] lo_q, lo_n, hi_q, hi_n;
    logic [1:0]           mode_q, mode_n;
    logic [DATA_SIZE-1:0] bin_q, bin_n, gray_q, gray_n;
    logic                 dir_q, dir_n;
    logic                 valid_q, valid_n;
    logic                 busy_q, busy_n;
    logic                 done_q, done_n;
    logic                 err_q, err_n;
    logic [CNT_W-1:0]     cnt_q, cnt_n;
    logic                 beat;

    assign beat = valid_q && out_ready;

    // Next-state and next-output logic.
    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_n = state_q;
        lo_n    = lo_q;
        hi_n    = hi_q;
        mode_n  = mode_q;
        bin_n   = bin_q;
        dir_n   = dir_q;
        valid_n = valid_q;
        busy_n  = busy_q;
        done_n  = 1'b0;
        err_n   = 1'b0;
        cnt_n   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (lo_lim <= hi_lim && mode != MODE_RSVD) begin
                        lo_n    = lo_lim;
                        hi_n    = hi_lim;
                        mode_n  = mode;
                        bin_n   = lo_lim;
                        dir_n   = 1'b1;
                        cnt_n   = '0;
                        valid_n = 1'b1;
                        busy_n  = 1'b1;
                        state_n = RUN;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end

            RUN: begin
                if (beat && cnt_q != '1) begin
                    cnt_n = cnt_q + CNT_W'(1);
                end

                if (stop) begin
                    // Abort: a coincident beat is counted but the index holds.
                    valid_n = 1'b0;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else if (beat) begin
                    // All boundary decisions compare against the limits, so the
                    // +1/-1 below never wraps past the index width.
                    unique case (mode_q)
                        MODE_ONESHOT: begin
                            if (bin_q == hi_q) begin
                                valid_n = 1'b0;
                                busy_n  = 1'b0;
                                done_n  = 1'b1;
                                state_n = IDLE;
                            end else begin
                                bin_n = bin_q + DATA_SIZE'(1);
                            end
                        end
                        MODE_WRAP: begin
                            bin_n = (bin_q == hi_q) ? lo_q : bin_q + DATA_SIZE'(1);
                        end
                        MODE_PINGPONG: begin
                            if (lo_q == hi_q) begin
                                bin_n = lo_q;
                                dir_n = 1'b1;
                            end else if (dir_q && bin_q == hi_q) begin
                                dir_n = 1'b0;
                                bin_n = hi_q - DATA_SIZE'(1);
                            end else if (!dir_q && bin_q == lo_q) begin
                                dir_n = 1'b1;
                                bin_n = lo_q + DATA_SIZE'(1);
                            end else begin
                                bin_n = dir_q ? bin_q + DATA_SIZE'(1)
                                              : bin_q - DATA_SIZE'(1);
                            end
                        end
                        default: begin
                            // Reserved mode is never latched; hold.
                            bin_n = bin_q;
                        end
                    endcase
                end
            end

            default: state_n = IDLE;
        endcase

        // Gray output is registered from the same next index as bin_out.
        gray_n = bin_n ^ (bin_n >> 1);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled before the edge.
    // NOTE: every register, including latched configuration, is reset so the
    // block comes out of reset in a fully defined state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lo_q    <= '0;
            hi_q    <= '0;
            mode_q  <= '0;
            bin_q   <= '0;
            gray_q  <= '0;
            dir_q   <= 1'b1;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            lo_q    <= lo_n;
            hi_q    <= hi_n;
            mode_q  <= mode_n;
            bin_q   <= bin_n;
            gray_q  <= gray_n;
            dir_q   <= dir_n;
            valid_q <= valid_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            err_q   <= err_n;
            cnt_q   <= cnt_n;
        end
    end

    assign out_valid = valid_q;
    assign bin_out   = bin_q;
    assign gray_out  = gray_q;
    assign dir_out   = dir_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cfg_err   = err_q;
    assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gray_seq_ctrl
//   Self-checking bench for gray_seq_ctrl. A behavioural model tracks a run
//   as a step count from the start; the expected index is derived from that
//   count arithmetically for each mode, and the Gray code bit by bit.
// -----------------------------------------------------------------------------
module tb_gray_seq_ctrl;

    localparam int DS      = 4;
    localparam int CW      = 16;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, stop, out_ready;
    logic [1:0]    mode;
    logic [DS-1:0] lo_lim, hi_lim;
    logic          out_valid, dir_out, busy, done, cfg_err;
    logic [DS-1:0] bin_out, gray_out;
    logic [CW-1:0] beat_cnt;

    gray_seq_ctrl #(.DATA_SIZE(DS), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .lo_lim    (lo_lim),
        .hi_lim    (hi_lim),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .bin_out   (bin_out),
        .gray_out  (gray_out),
        .dir_out   (dir_out),
        .busy      (busy),
        .done      (done),
        .cfg_err   (cfg_err),
        .beat_cnt  (beat_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state.
    bit m_run, m_valid, m_dir, m_done, m_err;
    int m_p, m_bin, m_cnt, m_lo, m_hi, m_mode;

    // Observation scratch for directed sequences.
    int obs_bin  [8];
    int obs_gray [8];
    int obs_dir  [8];
    int done_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int to_gray(input int b);
        int g = 0;
        for (int i = 0; i < DS; i++) begin
            int hi_bit = (i == DS - 1) ? 0 : ((b >> (i + 1)) & 1);
            g |= (((b >> i) & 1) ^ hi_bit) << i;
        end
        return g;
    endfunction

    // Index and direction after p advances from the start of a run.
    function automatic void index_of(input int p, output int b, output bit d);
        int span = m_hi - m_lo;
        int q;
        case (m_mode)
            0: begin b = m_lo + p; d = 1'b1; end
            1: begin b = m_lo + (p % (span + 1)); d = 1'b1; end
            default: begin
                if (span == 0) begin
                    b = m_lo; d = 1'b1;
                end else begin
                    q = p % (2 * span);
                    b = (q <= span) ? m_lo + q : m_lo + 2 * span - q;
                    d = (p == 0) || (q >= 1 && q <= span);
                end
            end
        endcase
    endfunction

    task automatic model_reset();
        m_run = 0; m_valid = 0; m_dir = 1; m_done = 0; m_err = 0;
        m_p = 0; m_bin = 0; m_cnt = 0; m_lo = 0; m_hi = 0; m_mode = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
        check({tag, ".bin"},   32'(bin_out),   32'(m_bin));
        check({tag, ".gray"},  32'(gray_out),  32'(to_gray(m_bin)));
        check({tag, ".dir"},   32'(dir_out),   32'(m_dir));
        check({tag, ".busy"},  32'(busy),      32'(m_run));
        check({tag, ".done"},  32'(done),      32'(m_done));
        check({tag, ".err"},   32'(cfg_err),   32'(m_err));
        check({tag, ".cnt"},   32'(beat_cnt),  32'(m_cnt));
    endtask

    // One clock with the currently driven inputs; model steps alongside.
    task automatic cycle(input string tag);
        bit n_run = m_run, n_valid = m_valid, n_done = 0, n_err = 0;
        int n_p = m_p, n_cnt = m_cnt;
        if (!m_run) begin
            if (start) begin
                if (int'(lo_lim) <= int'(hi_lim) && mode != 2'd3) begin
                    m_lo = int'(lo_lim); m_hi = int'(hi_lim); m_mode = int'(mode);
                    n_run = 1; n_p = 0; n_cnt = 0; n_valid = 1;
                end else begin
                    n_err = 1;
                end
            end
        end else begin
            if (out_ready && n_cnt < CNT_MAX) n_cnt++;
            if (stop) begin
                n_run = 0; n_valid = 0;
            end else if (out_ready) begin
                if (m_mode == 0 && m_bin == m_hi) begin
                    n_run = 0; n_valid = 0; n_done = 1;
                end else begin
                    n_p++;
                end
            end
        end
        @(posedge clk);
        #1;
        m_run = n_run; m_valid = n_valid; m_done = n_done; m_err = n_err;
        m_p = n_p; m_cnt = n_cnt;
        if (m_run) index_of(m_p, m_bin, m_dir);
        check_all(tag);
    endtask

    task automatic drive(input bit s, input bit p, input int md, input int lo, input int hi, input bit rdy);
        start = s; stop = p; mode = 2'(md); lo_lim = DS'(lo); hi_lim = DS'(hi); out_ready = rdy;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        // ---------------- Reset with random inputs ----------------
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'($urandom));
            @(posedge clk);
            #1;
            check_all("reset");
        end
        #3;
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle("idle");

        // ---------------- One-shot 3..6 ----------------
        drive(1, 0, 0, 3, 6, 1);
        cycle("os.start");
        obs_bin[0] = int'(bin_out); obs_gray[0] = int'(gray_out);
        drive(0, 0, 0, 0, 0, 1);
        for (int i = 1; i < 4; i++) begin
            cycle("os.run");
            obs_bin[i] = int'(bin_out); obs_gray[i] = int'(gray_out);
        end
        done_seen = 0;
        for (int i = 0; i < 3; i++) begin
            cycle("os.tail");
            done_seen += int'(done);
        end
        begin
            int eb[4] = '{3, 4, 5, 6};
            int eg[4] = '{2, 6, 7, 5};
            for (int i = 0; i < 4; i++) begin
                check("os.seq_bin", 32'(obs_bin[i]), 32'(eb[i]));
                check("os.seq_gray", 32'(obs_gray[i]), 32'(eg[i]));
            end
        end
        check("os.done_pulses", 32'(done_seen), 32'd1);
        check("os.beats", 32'(beat_cnt), 32'd4);
        check("os.valid_low", 32'(out_valid), 32'd0);

        // ---------------- Wrap 14..15 with backpressure ----------------
        drive(1, 0, 1, 14, 15, 0);
        cycle("wr.start");
        begin
            bit rdy[6] = '{1, 0, 1, 1, 0, 1};
            for (int i = 0; i < 6; i++) begin
                drive(0, 0, 3, 0, 0, rdy[i]);
                cycle("wr.run");
            end
        end
        drive(0, 1, 0, 0, 0, 0);
        cycle("wr.stop");
        check("wr.beats", 32'(beat_cnt), 32'd4);
        check("wr.no_done", 32'(done), 32'd0);
        drive(0, 0, 0, 0, 0, 1);
        cycle("wr.idle");

        // ---------------- Ping-pong 0..3 ----------------
        drive(1, 0, 2, 0, 3, 1);
        cycle("pp.start");
        obs_bin[0] = int'(bin_out); obs_gray[0] = int'(gray_out); obs_dir[0] = int'(dir_out);
        drive(0, 0, 0, 9, 2, 1);
        for (int i = 1; i < 8; i++) begin
            cycle("pp.run");
            obs_bin[i] = int'(bin_out); obs_gray[i] = int'(gray_out); obs_dir[i] = int'(dir_out);
        end
        begin
            int eb[8] = '{0, 1, 2, 3, 2, 1, 0, 1};
            int eg[8] = '{0, 1, 3, 2, 3, 1, 0, 1};
            int ed[8] = '{1, 1, 1, 1, 0, 0, 0, 1};
            for (int i = 0; i < 8; i++) begin
                check("pp.seq_bin", 32'(obs_bin[i]), 32'(eb[i]));
                check("pp.seq_gray", 32'(obs_gray[i]), 32'(eg[i]));
                check("pp.seq_dir", 32'(obs_dir[i]), 32'(ed[i]));
            end
        end
        drive(0, 1, 0, 0, 0, 1);
        cycle("pp.stop");

        // ---------------- Ping-pong with lo == hi ----------------
        drive(1, 0, 2, 7, 7, 1);
        cycle("pp1.start");
        drive(0, 0, 2, 7, 7, 1);
        for (int i = 0; i < 4; i++) cycle("pp1.run");
        drive(0, 1, 0, 0, 0, 1);
        cycle("pp1.stop");

        // ---------------- Full-range wrap ----------------
        drive(1, 0, 1, 0, 15, 1);
        cycle("full.start");
        drive(0, 0, 1, 0, 15, 1);
        for (int i = 0; i < 18; i++) cycle("full.run");
        drive(0, 1, 0, 0, 0, 1);
        cycle("full.stop");

        // ---------------- Config errors ----------------
        drive(1, 0, 0, 9, 2, 1);
        cycle("err.lim");
        check("err.lim_pulse", 32'(cfg_err), 32'd1);
        drive(1, 0, 3, 2, 9, 1);
        cycle("err.mode");
        check("err.mode_pulse", 32'(cfg_err), 32'd1);
        drive(0, 0, 0, 0, 0, 1);
        cycle("err.clear");
        drive(1, 0, 0, 2, 4, 1);
        cycle("err.legal");
        drive(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cycle("err.legal_run");

        // ---------------- Async reset mid-run ----------------
        drive(1, 0, 1, 5, 9, 1);
        cycle("ar.start");
        drive(0, 0, 1, 5, 9, 1);
        for (int i = 0; i < 4; i++) cycle("ar.run");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("ar.immediate");
        @(posedge clk);
        #1;
        check_all("ar.held");
        #3;
        rst_n = 1'b1;
        drive(1, 0, 2, 1, 4, 1);
        cycle("ar.restart");

        // ---------------- Randomised traffic ----------------
        for (int i = 0; i < 500; i++) begin
            drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
            cycle("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
